fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Four-requester write arbiter for a FIFO's write port: round-robin grants with
// a burst limit that shrinks to a single word when the FIFO is half full.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [3:0]            req,
    input  logic [DATA_WIDTH-1:0] data_0,
    input  logic [DATA_WIDTH-1:0] data_1,
    input  logic [DATA_WIDTH-1:0] data_2,
    input  logic [DATA_WIDTH-1:0] data_3,
    input  logic                  wfull,
    input  logic                  half_full,
    output logic [3:0]            gnt,
    output logic [3:0]            ack,
    output logic                  winc,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [1:0]            owner_id,
    output logic                  busy,
    output logic [15:0]           stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [1:0]              rr_ptr;
    logic [3:0]              burst_cnt;
    logic [3:0]              burst_lim;
    logic [1:0]              pick;
    logic [1:0]              idx;
    logic                    owner_req;
    logic                    last_word;
    logic                    release_own;
    logic [DATA_WIDTH-1:0]   owner_data;

    // Round-robin search: scan downwards so the nearest set bit after rr_ptr wins.
    always_comb begin
        pick = rr_ptr;
        idx  = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_ptr + 2'(i);
            if (req[idx]) pick = idx;
        end
    end

    always_comb begin
        owner_data = data_0;
        case (owner_id)
            2'd0: owner_data = data_0;
            2'd1: owner_data = data_1;
            2'd2: owner_data = data_2;
            2'd3: owner_data = data_3;
            default: owner_data = data_0;
        endcase
    end

    assign busy        = (state == OWN);
    assign owner_req   = req[owner_id];
    // Reset gates the write strobe directly so a burst cut by reset writes nothing.
    assign winc        = busy && owner_req && !wfull && wrst;
    assign ack         = winc ? (4'b0001 << owner_id) : 4'b0000;
    assign wdata       = busy ? owner_data : '0;
    assign last_word   = winc && (burst_cnt == burst_lim - 4'd1);
    assign release_own = !owner_req || last_word;

    // NOTE: next-state logic assigns its default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = OWN;
            OWN:     if (release_own) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge wclk) begin
        if (!wrst) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            owner_id  <= 2'd0;
            rr_ptr    <= 2'd0;
            burst_cnt <= 4'd0;
            burst_lim <= 4'(MAX_BURST);
            stall_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt       <= 4'b0001 << pick;
                        owner_id  <= pick;
                        burst_cnt <= 4'd0;
                        burst_lim <= half_full ? 4'd1 : 4'(MAX_BURST);
                    end
                end
                OWN: begin
                    if (release_own) begin
                        gnt    <= 4'b0000;
                        rr_ptr <= owner_id + 2'd1;
                    end else begin
                        if (winc) burst_cnt <= burst_cnt + 4'd1;
                        if (wfull && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                default: gnt <= 4'b0000;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single owner, fairness, throttle, stall,
// early release and mid-burst reset, with hand-computed expectations.
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        wrst;
    logic [3:0]  req;
    logic [7:0]  data_0, data_1, data_2, data_3;
    logic        wfull, half_full;
    logic [3:0]  gnt, ack;
    logic        winc;
    logic [7:0]  wdata;
    logic [1:0]  owner_id;
    logic        busy;
    logic [15:0] stall_cnt;

    logic [7:0]  dv [4];
    int          n_tests = 0;
    int          n_fail  = 0;

    fifo_wr_arbiter #(.DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .wclk(wclk), .wrst(wrst), .req(req),
        .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
        .wfull(wfull), .half_full(half_full),
        .gnt(gnt), .ack(ack), .winc(winc), .wdata(wdata),
        .owner_id(owner_id), .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    // Checks the visible outputs of the current cycle after inputs settle.
    task automatic exp_cycle(input string tag, input logic [3:0] eg, input logic ew,
                             input logic [7:0] ed);
        #1;
        check({tag, "/gnt"},   32'(gnt),   32'(eg));
        check({tag, "/winc"},  32'(winc),  32'(ew));
        check({tag, "/wdata"}, 32'(wdata), 32'(ed));
        check({tag, "/ack"},   32'(ack),   32'(ew ? eg : 4'b0000));
        check({tag, "/busy"},  32'(busy),  32'(eg != 4'b0000));
    endtask

    task automatic do_reset();
        wrst = 1'b0; req = 4'b0000; wfull = 1'b0; half_full = 1'b0;
        tick();
        check("rst/gnt",   32'(gnt),       32'h0);
        check("rst/busy",  32'(busy),      32'h0);
        check("rst/owner", 32'(owner_id),  32'h0);
        check("rst/stall", 32'(stall_cnt), 32'h0);
        check("rst/winc",  32'(winc),      32'h0);
        wrst = 1'b1;
    endtask

    // Structural invariants sampled mid-cycle, away from the active edge.
    always @(negedge wclk) begin
        if (wrst === 1'b1) begin
            check("inv/onehot", 32'($countones(gnt) <= 1), 32'h1);
            check("inv/nofull", 32'(winc && wfull), 32'h0);
        end
    end

    initial begin
        data_0 = 8'hA0; data_1 = 8'hB1; data_2 = 8'hC2; data_3 = 8'hD3;
        dv[0] = 8'hA0; dv[1] = 8'hB1; dv[2] = 8'hC2; dv[3] = 8'hD3;
        wrst = 1'b0; req = 4'b0000; wfull = 1'b0; half_full = 1'b0;
        tick();

        // Single requester: grant, four words, one bubble, regrant, then release.
        do_reset();
        req = 4'b0001;
        exp_cycle("single/idle", 4'b0000, 1'b0, 8'h00);
        tick();
        for (int w = 0; w < 4; w++) begin
            exp_cycle("single/word", 4'b0001, 1'b1, 8'hA0);
            tick();
        end
        exp_cycle("single/bubble", 4'b0000, 1'b0, 8'h00);
        tick();
        exp_cycle("single/regrant", 4'b0001, 1'b1, 8'hA0);
        tick();
        req = 4'b0000;
        exp_cycle("single/drop", 4'b0001, 1'b0, 8'hA0);
        tick();
        exp_cycle("single/idle2", 4'b0000, 1'b0, 8'h00);

        // Fairness: all request; order 0,1,2,3,0 with four words each.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            for (int w = 0; w < 4; w++) begin
                exp_cycle("fair/word", 4'b0001 << (k % 4), 1'b1, dv[k % 4]);
                check("fair/owner", 32'(owner_id), 32'(k % 4));
                tick();
            end
            exp_cycle("fair/bubble", 4'b0000, 1'b0, 8'h00);
        end

        // Throttle: half full limits each grant to one word, owners alternate.
        do_reset();
        req = 4'b0011; half_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_cycle("thr/word", 4'b0001 << (k % 2), 1'b1, dv[k % 2]);
            tick();
            exp_cycle("thr/bubble", 4'b0000, 1'b0, 8'h00);
        end

        // Full stall after the second word of a burst.
        do_reset();
        req = 4'b0001;
        tick();
        exp_cycle("stall/w1", 4'b0001, 1'b1, 8'hA0);
        tick();
        exp_cycle("stall/w2", 4'b0001, 1'b1, 8'hA0);
        tick();
        wfull = 1'b1;
        for (int s = 0; s < 5; s++) begin
            exp_cycle("stall/held", 4'b0001, 1'b0, 8'hA0);
            tick();
        end
        check("stall/cnt", 32'(stall_cnt), 32'd5);
        wfull = 1'b0;
        exp_cycle("stall/w3", 4'b0001, 1'b1, 8'hA0);
        tick();
        exp_cycle("stall/w4", 4'b0001, 1'b1, 8'hA0);
        tick();
        exp_cycle("stall/done", 4'b0000, 1'b0, 8'h00);
        check("stall/cnt2", 32'(stall_cnt), 32'd5);

        // Early release: owner 0 drops after one word; requester 2 is next.
        do_reset();
        req = 4'b0101;
        tick();
        exp_cycle("early/w1", 4'b0001, 1'b1, 8'hA0);
        tick();
        req = 4'b0100;
        exp_cycle("early/drop", 4'b0001, 1'b0, 8'hA0);
        tick();
        exp_cycle("early/bubble", 4'b0000, 1'b0, 8'h00);
        tick();
        exp_cycle("early/next", 4'b0100, 1'b1, 8'hC2);
        check("early/owner", 32'(owner_id), 32'd2);

        // Reset mid-burst after some stall cycles.
        do_reset();
        req = 4'b1000;
        tick();
        exp_cycle("mid/w1", 4'b1000, 1'b1, 8'hD3);
        tick();
        wfull = 1'b1;
        exp_cycle("mid/stall", 4'b1000, 1'b0, 8'hD3);
        tick();
        check("mid/stallcnt", 32'(stall_cnt), 32'd1);
        wfull = 1'b0; wrst = 1'b0;
        exp_cycle("mid/rstw2", 4'b1000, 1'b0, 8'hD3);
        tick();
        check("mid/gnt0",   32'(gnt),       32'h0);
        check("mid/stall0", 32'(stall_cnt), 32'h0);
        check("mid/busy0",  32'(busy),      32'h0);
        wrst = 1'b1; req = 4'b1010;
        tick();
        exp_cycle("mid/regrant", 4'b0010, 1'b1, 8'hB1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
